buttfly_sched: RTL and testbench
================================

Name: buttfly_sched

Overview:
- Scheduler sharing one combinational butterfly unit (sum/difference, 16-bit in, 17-bit out) across a block of N buffered samples.
- Accepts a stream of samples into an internal buffer. When the block is complete, issues pairs (x[k], x[k+N/2]) for k = 0..N/2-1 to the butterfly, one per cycle.
- Registers each result pair into a valid/ready output stage.
- Sits between the sample source and the downstream stage of a radix-2 stage datapath.

Parameters:
- DATA_W, 16, sample width; butterfly result width is DATA_W+1.
- N, 8, samples per block; power of two, N >= 4.
- IDX_W, log2(N/2), derived local, width of pair index.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample accept; high only in FILL.
- in_data  in  DATA_W  sample.
- bf_in_0  out  DATA_W  butterfly operand 0 = mem[k].
- bf_in_1  out  DATA_W  butterfly operand 1 = mem[k+N/2].
- bf_res_0  in  DATA_W+1  butterfly sum result (combinational from bf_in_*).
- bf_res_1  in  DATA_W+1  butterfly difference result.
- out_valid  out  1  result pair valid.
- out_ready  in  1  downstream accept.
- out_res_0  out  DATA_W+1  registered sum.
- out_res_1  out  DATA_W+1  registered difference.
- out_idx  out  IDX_W  pair index k of current output.
- busy  out  1  high in RUN or DRAIN.
- block_done  out  1  one-cycle pulse when the last pair of a block is accepted downstream.

Behaviour:
- Clock, reset and state:
  - One clock domain (clk).
  - rst_n asynchronous active-low; all state cleared immediately on assertion.
  - States: FILL, RUN, DRAIN. Reset state is FILL.
- Reset values:
  - in_ready = 1, out_valid = 0, out_res_0/1 = 0, out_idx = 0.
  - busy = 0, block_done = 0, bf_in_0/1 = 0.
  - Write counter wcnt = 0, pair counter k = 0.
  - Buffer contents are not reset and are never observable before being written.
- FILL:
  - in_ready = 1.
  - On in_valid && in_ready: mem[wcnt] <= in_data, wcnt++.
  - On the Nth accept: wcnt -> 0, k -> 0, next state RUN.
  - Gaps in in_valid stall filling without penalty.
- RUN:
  - in_ready = 0.
  - bf_in_0 = mem[k], bf_in_1 = mem[k+N/2], combinational from k.
  - fire = !out_valid || out_ready.
  - On fire: out_res_0 <= bf_res_0, out_res_1 <= bf_res_1, out_idx <= k, out_valid <= 1, k++.
  - Fire at k = N/2-1 -> next state DRAIN.
  - Throughput is 1 pair/clk with out_ready held high. Latency is 1 clk from operand drive to out_valid.
- Outside RUN: bf_in_0/1 = 0.
- DRAIN:
  - in_ready = 0.
  - On out_valid && out_ready: out_valid <= 0, block_done <= 1 for exactly one cycle, next state FILL.
- Output handshake:
  - out_valid stays asserted and out_res_*/out_idx stay stable until out_valid && out_ready.
  - No pair is dropped or duplicated.
  - In RUN, accept and fire in the same cycle load the next pair, keeping out_valid = 1.
- Arithmetic:
  - The controller does not compute; it samples bf_res_* verbatim.
  - The butterfly used in verification computes:
    - res_0 = zero-extended in_0 + in_1.
    - res_1 = (in_0 - in_1) mod 2^(DATA_W+1).
- Boundaries:
  - wcnt and k wrap to 0 at block end.
  - in_valid during RUN/DRAIN is ignored; no sample is written.
  - Reset mid-FILL or mid-RUN discards the partial block.
  - After reset release, the next N accepted samples form a fresh block.

Test Plan:
- Reset: hold rst_n low mid-RUN with out_valid = 1 -> out_valid, busy and bf_in_0/1 drop to 0 asynchronously; in_ready = 1.
- Nominal: samples 1..8 (N=8), out_ready = 1 -> four consecutive outputs:
  - idx0: res_0 = 6, res_1 = 0x1FFFC.
  - idx1: res_0 = 8, res_1 = 0x1FFFC.
  - idx2: res_0 = 10, res_1 = 0x1FFFC.
  - idx3: res_0 = 12, res_1 = 0x1FFFC.
  - block_done pulses once after the idx3 handshake; in_ready is 0 throughout RUN/DRAIN.
- Backpressure: drop out_ready for 3 clks while idx1 is presented -> idx1 values held stable, k frozen, then idx2 and idx3 follow with no loss or duplication.
- Extremes:
  - mem[0] = mem[4] = 0xFFFF -> idx0 res_0 = 0x1FFFE, res_1 = 0.
  - mem[1] = 0, mem[5] = 0xFFFF -> idx1 res_0 = 0x0FFFF, res_1 = 0x10001.
- Input gaps: in_valid toggled 1/0 during FILL, plus in_valid = 1 during RUN -> only the first 8 accepted FILL beats are stored; outputs match the 8-sample model.
- Back-to-back blocks: a second block is streamed immediately after block_done -> correct results, no stale data from the first block.

Source files
------------

// File: rtl/buttfly_sched_if.sv
// Stream and butterfly-operand bundle for the butterfly scheduler.
// The slave modport is the scheduler's view; master is the surrounding datapath.
interface buttfly_sched_if #(
    parameter int DATA_W = 16,
    parameter int N      = 8
);
    localparam int IDX_W = $clog2(N / 2);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] bf_in_0;
    logic [DATA_W-1:0] bf_in_1;
    logic [DATA_W:0]   bf_res_0;
    logic [DATA_W:0]   bf_res_1;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W:0]   out_res_0;
    logic [DATA_W:0]   out_res_1;
    logic [IDX_W-1:0]  out_idx;
    logic              busy;
    logic              block_done;

    modport slave (
        input  in_valid, in_data, bf_res_0, bf_res_1, out_ready,
        output in_ready, bf_in_0, bf_in_1, out_valid, out_res_0, out_res_1,
               out_idx, busy, block_done
    );

    modport master (
        output in_valid, in_data, bf_res_0, bf_res_1, out_ready,
        input  in_ready, bf_in_0, bf_in_1, out_valid, out_res_0, out_res_1,
               out_idx, busy, block_done
    );
endinterface

// File: rtl/buttfly_sched.sv
// Buffers a block of N samples, then feeds pairs (x[k], x[k+N/2]) through one
// shared external butterfly and registers each result pair behind valid/ready.
module buttfly_sched #(
    parameter int DATA_W = 16,
    parameter int N      = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    buttfly_sched_if.slave bus
);
    localparam int IDX_W = $clog2(N / 2);
    localparam int CNT_W = $clog2(N);

    localparam logic [1:0] S_FILL  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_wcnt;
    logic [IDX_W-1:0]  r_k;
    logic [DATA_W-1:0] r_mem [N];
    logic              r_out_valid;
    logic [DATA_W:0]   r_out_res_0;
    logic [DATA_W:0]   r_out_res_1;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_block_done;

    logic              w_run;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_fire;
    logic              w_out_hs;
    logic              w_wcnt_last;
    logic              w_k_last;
    logic [CNT_W-1:0]  w_lo_addr;
    logic [CNT_W-1:0]  w_hi_addr;

    assign w_run       = (r_state == S_RUN);
    assign w_in_ready  = (r_state == S_FILL);
    assign w_accept    = w_in_ready && bus.in_valid;
    assign w_fire      = w_run && (!r_out_valid || bus.out_ready);
    assign w_out_hs    = r_out_valid && bus.out_ready;
    assign w_wcnt_last = (r_wcnt == {CNT_W{1'b1}});
    assign w_k_last    = (r_k == {IDX_W{1'b1}});

    // N/2 is a power of two, so the upper half of the buffer is just the MSB set.
    assign w_lo_addr = {1'b0, r_k};
    assign w_hi_addr = {1'b1, r_k};

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wcnt] <= bus.in_data;
        end
    end

    assign bus.bf_in_0    = w_run ? r_mem[w_lo_addr] : '0;
    assign bus.bf_in_1    = w_run ? r_mem[w_hi_addr] : '0;
    assign bus.in_ready   = w_in_ready;
    assign bus.busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.out_valid  = r_out_valid;
    assign bus.out_res_0  = r_out_res_0;
    assign bus.out_res_1  = r_out_res_1;
    assign bus.out_idx    = r_out_idx;
    assign bus.block_done = r_block_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FILL;
            r_wcnt       <= '0;
            r_k          <= '0;
            r_out_valid  <= 1'b0;
            r_out_res_0  <= '0;
            r_out_res_1  <= '0;
            r_out_idx    <= '0;
            r_block_done <= 1'b0;
        end else begin
            r_block_done <= 1'b0;
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_wcnt <= r_wcnt + CNT_W'(1);
                        if (w_wcnt_last) begin
                            r_wcnt  <= '0;
                            r_k     <= '0;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // Accept and reload share a cycle, so out_valid stays high at full rate.
                    if (w_fire) begin
                        r_out_res_0 <= bus.bf_res_0;
                        r_out_res_1 <= bus.bf_res_1;
                        r_out_idx   <= r_k;
                        r_out_valid <= 1'b1;
                        r_k         <= r_k + IDX_W'(1);
                        if (w_k_last) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_hs) begin
                        r_out_valid  <= 1'b0;
                        r_block_done <= 1'b1;
                        r_state      <= S_FILL;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_buttfly_sched.sv
// Scoreboard bench for buttfly_sched: a behavioural butterfly closes the loop,
// expected pairs are queued per block and compared as the DUT presents them.
module tb_buttfly_sched;
    localparam int DATA_W = 16;
    localparam int N      = 8;

    typedef struct {
        logic [16:0] r0;
        logic [16:0] r1;
        logic [1:0]  idx;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   done_cnt;
    int   done_exp;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [15:0] blk [8];

    buttfly_sched_if #(.DATA_W(DATA_W), .N(N)) bus ();

    buttfly_sched #(.DATA_W(DATA_W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        bus.bf_res_0 = {1'b0, bus.bf_in_0} + {1'b0, bus.bf_in_1};
        bus.bf_res_1 = {1'b0, bus.bf_in_0} - {1'b0, bus.bf_in_1};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
            if (bus.block_done) done_cnt++;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q[0];
                    chk("res_0", {15'd0, bus.out_res_0}, {15'd0, mon_e.r0});
                    chk("res_1", {15'd0, bus.out_res_1}, {15'd0, mon_e.r1});
                    chk("idx", {30'd0, bus.out_idx}, {30'd0, mon_e.idx});
                    if (bus.out_ready) begin
                        $display("out idx=%0d res0=%h res1=%h", bus.out_idx, bus.out_res_0, bus.out_res_1);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic push_exp();
        exp_t e;
        for (int k = 0; k < N / 2; k++) begin
            e.r0  = 17'(blk[k]) + 17'(blk[k + N / 2]);
            e.r1  = 17'(blk[k]) - 17'(blk[k + N / 2]);
            e.idx = 2'(k);
            exp_q.push_back(e);
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 after the beat is accepted.
    task automatic send(input logic [15:0] d, input bit gap);
        bit acc;
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        acc = 1'b0;
        while (!acc && t < 200) begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            t++;
        end
        if (!acc) chk("in_ready_timeout", 32'd0, 32'd1);
        $display("in data=%h", d);
        if (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic send_block(input bit gaps);
        push_exp();
        for (int i = 0; i < N; i++) send(blk[i], gaps);
        bus.in_valid = 1'b0;
        done_exp++;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_cnt < done_exp && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (2) begin @(posedge clk); #1; end
        chk("block_done_count", 32'(done_cnt), 32'(done_exp));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_blk();
        for (int i = 0; i < N; i++) blk[i] = 16'($urandom);
    endtask

    initial begin
        int t;
        n_chk = 0; n_err = 0; done_cnt = 0; done_exp = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_block_done", {31'd0, bus.block_done}, 32'd0);
        chk("rst_out_res_0", {15'd0, bus.out_res_0}, 32'd0);
        chk("rst_out_res_1", {15'd0, bus.out_res_1}, 32'd0);
        chk("rst_out_idx", {30'd0, bus.out_idx}, 32'd0);
        chk("rst_bf_in_0", {16'd0, bus.bf_in_0}, 32'd0);
        chk("rst_bf_in_1", {16'd0, bus.bf_in_1}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal: samples 1..8
        for (int i = 0; i < N; i++) blk[i] = 16'(i + 1);
        send_block(1'b0);
        wait_done();

        // Backpressure while idx1 is presented
        rand_blk();
        send_block(1'b0);
        t = 0;
        while (!(bus.out_valid && bus.out_idx == 2'd1) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("bp_idx1_seen", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_bf_in_0", {16'd0, bus.bf_in_0}, {16'd0, blk[2]});
            chk("bp_bf_in_1", {16'd0, bus.bf_in_1}, {16'd0, blk[6]});
        end
        bus.out_ready = 1'b1;
        wait_done();

        // Extremes
        blk[0] = 16'hFFFF; blk[4] = 16'hFFFF; blk[1] = 16'h0000; blk[5] = 16'hFFFF;
        blk[2] = 16'h8000; blk[6] = 16'h7FFF; blk[3] = 16'h0001; blk[7] = 16'h0000;
        send_block(1'b0);
        wait_done();

        // Gapped fill, then junk on in_valid during RUN
        rand_blk();
        send_block(1'b1);
        bus.in_valid = 1'b1; bus.in_data = 16'hDEAD;
        repeat (3) begin @(posedge clk); #1; end
        bus.in_valid = 1'b0;
        wait_done();

        // Back-to-back blocks
        rand_blk();
        send_block(1'b0);
        rand_blk();
        send_block(1'b0);
        wait_done();

        // Reset mid-RUN with out_valid high
        rand_blk();
        send_block(1'b0);
        done_exp--;
        bus.out_ready = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("mid_run_valid", {31'd0, bus.out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_bf_in_0", {16'd0, bus.bf_in_0}, 32'd0);
        chk("arst_bf_in_1", {16'd0, bus.bf_in_1}, 32'd0);
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        exp_q.delete();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Partial fill discarded by reset
        for (int i = 0; i < 5; i++) send(16'h5A00 + 16'(i), 1'b0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rand_blk();
        send_block(1'b0);
        wait_done();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
